// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with power-of-two depth, programmable
// almost-full/almost-empty thresholds, a registered read port with a valid
// strobe, full-throughput read+write (including when full), and sticky
// overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;
    logic              ovf_q;
    logic              unf_q;

    logic rd_acc;
    logic wr_acc;

    // Accept logic: a full FIFO still takes a write when a read frees a slot
    // in the same cycle; an empty FIFO never forwards a same-cycle write.
    always_comb begin
        rd_acc = rd_en && !empty;
        wr_acc = wr_en && (!full || rd_acc);
    end

    // Status flags decode the registered occupancy directly (no lookahead).
    always_comb begin
        full         = (cnt == DEPTH_C);
        empty        = (cnt == '0);
        almost_full  = (cnt >= AF_C);
        almost_empty = (cnt <= AE_C);
    end

    // Storage write; the array is not reset, and writes are dropped while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous accept leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // ---- stage p1: registered read port (reads the slot before any same-cycle write lands) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) rd_data_p1 <= mem[rd_ptr];
        end
    end

    // Sticky error flags; a new rejection wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) ovf_q <= 1'b1;
            else if (err_clr)     ovf_q <= 1'b0;
            if (rd_en && !rd_acc) unf_q <= 1'b1;
            else if (err_clr)     unf_q <= 1'b0;
        end
    end

    assign rd_data   = rd_data_p1;
    assign rd_valid  = vld_p1;
    assign count     = cnt;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
// Every cycle is compared against a queue-based reference model; a directed
// vector table and hand-written corner sequences add fixed expectations.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 2;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [4:0]        count;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    logic              m_vld = 1'b0;
    logic [DATA_W-1:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, written from the FIFO's rules on a queue.
    task automatic model_edge(input logic r, input logic w, input logic [DATA_W-1:0] wd,
                              input logic rd, input logic clr);
        bit rd_ok;
        bit wr_ok;
        if (r) begin
            q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_vld  = 1'b0;
            m_data = '0;
        end else begin
            rd_ok = rd && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                m_data = q.pop_front();
                m_vld  = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            if (wr_ok) q.push_back(wd);
            if (w && !wr_ok) m_ovf = 1'b1;
            else if (clr)    m_ovf = 1'b0;
            if (rd && !rd_ok) m_unf = 1'b1;
            else if (clr)     m_unf = 1'b0;
        end
    endtask

    task automatic check_model();
        check("count",        32'(count),        32'(q.size()));
        check("empty",        32'(empty),        32'(q.size() == 0));
        check("full",         32'(full),         32'(q.size() == DEPTH));
        check("almost_full",  32'(almost_full),  32'(q.size() >= AF));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
        check("rd_valid",     32'(rd_valid),     32'(m_vld));
        check("rd_data",      32'(rd_data),      32'(m_data));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
    endtask

    // Drive one cycle (inputs applied at negedge), then compare at the next negedge.
    task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] wd,
                        input logic rd, input logic clr);
        rst = r; wr_en = w; wr_data = wd; rd_en = rd; err_clr = clr;
        @(posedge clk);
        model_edge(r, w, wd, rd, clr);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        logic [4:0] e_cnt;
        logic       e_vld;
        logic [7:0] e_data;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;

        //           rst  wr  wd     rd  clr  cnt vld data  ovf unf
        tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 5'd0,1'b0,8'h00,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,8'h00,1'b0,1'b0, 5'd0,1'b0,8'h00,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,8'h00,1'b1,1'b0, 5'd0,1'b0,8'h00,1'b0,1'b1};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b0,1'b1, 5'd0,1'b0,8'h00,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b1,8'h11,1'b0,1'b0, 5'd1,1'b0,8'h00,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,8'h22,1'b1,1'b0, 5'd1,1'b1,8'h11,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,8'h00,1'b0,1'b0, 5'd1,1'b0,8'h11,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b1,8'h33,1'b1,1'b0, 5'd1,1'b1,8'h22,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b0, 5'd0,1'b1,8'h33,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b1,8'hA5,1'b1,1'b0, 5'd1,1'b0,8'h33,1'b0,1'b1};
        tbl[10] = '{1'b0,1'b0,8'h00,1'b1,1'b0, 5'd0,1'b1,8'hA5,1'b0,1'b1};
        tbl[11] = '{1'b0,1'b0,8'h00,1'b1,1'b1, 5'd0,1'b0,8'hA5,1'b0,1'b1};
        tbl[12] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 5'd0,1'b0,8'hA5,1'b0,1'b0};

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
            check("tbl_count",     32'(count),     32'(tbl[i].e_cnt));
            check("tbl_rd_valid",  32'(rd_valid),  32'(tbl[i].e_vld));
            check("tbl_rd_data",   32'(rd_data),   32'(tbl[i].e_data));
            check("tbl_overflow",  32'(overflow),  32'(tbl[i].e_ovf));
            check("tbl_underflow", 32'(underflow), 32'(tbl[i].e_unf));
        end

        // Fill 0x00..0x0F: almost_full after the 14th write, full after the 16th
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            check("fill_almost_full", 32'(almost_full), 32'(i >= 13));
            check("fill_full",        32'(full),        32'(i == 15));
        end
        step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_17th_write", 32'(overflow), 32'd1);
        check("ovf_count",      32'(count),    32'd16);

        // Full with simultaneous read+write for 20 cycles across the wrap
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            check("full_rw_count", 32'(count),   32'd16);
            check("full_rw_data",  32'(rd_data), 32'(i < 16 ? i : 8'h40 + i - 16));
        end

        // err_clr alone clears; err_clr with a rejected write keeps overflow set
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_overflow", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        check("clr_vs_set_overflow", 32'(overflow), 32'd1);

        // Drain 16 words and confirm empty afterwards
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("drain_vld_drop", 32'(rd_valid), 32'd0);

        // Reset mid-burst at count 9, then verify ordering restarts cleanly
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd9);
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_vld",   32'(rd_valid), 32'd0);
        check("rst_unf",   32'(underflow), 32'd0);
        step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h5B, 1'b1, 1'b0);
        check("post_rst_data0", 32'(rd_data), 32'h5A);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_data1", 32'(rd_data), 32'h5B);

        // Randomized traffic with biased phases to visit full and empty often
        for (int i = 0; i < 3000; i++) begin
            int unsigned wp;
            int unsigned rp;
            wp = ((i / 64) % 2 == 0) ? 75 : 30;
            rp = 105 - wp;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < wp),
                 8'($urandom),
                 ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
